// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stalls, bubbles, squashes and halt drain for a
// five-stage pipeline, plus saturating stall/flush performance counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_usesRt,
    input  logic             ex_dREN,
    input  logic             ex_rfWEN,
    input  logic [4:0]       ex_dest,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_brTaken,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             dmem_mask,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DDONE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               halt_r;
    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;
    logic               memop_s;
    logic               loaduse_s;
    logic               advance_s;
    logic               stall_inc_s;
    logic               flush_inc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state, advance decision and all pipeline control outputs
    always_comb begin
        memop_s      = mem_dREN | mem_dWEN;
        loaduse_s    = ex_dREN & ex_rfWEN & (ex_dest != 5'd0) &
                       ((ex_dest == id_rs) | (id_usesRt & (ex_dest == id_rt)));
        advance_s    = 1'b0;
        next_state_s = state_r;
        dmem_mask    = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;

        case (state_r)
            RUN: begin
                advance_s = ihit & (~memop_s | dhit);
                if (advance_s & mem_halt) begin
                    next_state_s = HALTED;
                end else if (memop_s & dhit & ~ihit) begin
                    next_state_s = DDONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DDONE: begin
                // The data side already completed; only the fetch is outstanding.
                advance_s = ihit;
                dmem_mask = 1'b1;
                if (ihit) begin
                    next_state_s = mem_halt ? HALTED : RUN;
                end else begin
                    next_state_s = DDONE;
                end
            end
            HALTED: begin
                advance_s    = 1'b0;
                dmem_mask    = 1'b1;
                next_state_s = HALTED;
            end
            default: begin
                advance_s    = 1'b0;
                next_state_s = RUN;
            end
        endcase

        if (state_r == HALTED) begin
            pc_en = 1'b0;
        end else if (!advance_s) begin
            stall_inc_s = 1'b1;
        end else if (mem_brTaken | mem_halt) begin
            // A squash wins over a load-use bubble: the younger instructions die anyway.
            pc_en        = ~mem_halt;
            if_id_en     = 1'b1;
            id_ex_en     = 1'b1;
            ex_mem_en    = 1'b1;
            mem_wb_en    = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc_s  = mem_brTaken;
        end else if (loaduse_s) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
            stall_inc_s = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
        end
    end

    // State, halt flag and saturating performance counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= RUN;
            halt_r      <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            halt_r  <= (next_state_s == HALTED);
            if (stall_inc_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_inc_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign halt      = halt_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: single-cycle vector table plus hand-written
// sequences for the data-before-instruction wait, halt, reset and saturation.
module tb_hazard_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, id_usesRt, ex_dREN, ex_rfWEN;
    logic [4:0]  id_rs, id_rt, ex_dest;
    logic        mem_dREN, mem_dWEN, mem_brTaken, mem_halt;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, dmem_mask, halt;
    logic [15:0] stall_cnt, flush_cnt;
    logic [8:0]  outs;

    logic        ihit4;
    logic        pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
    logic        if_id_flush4, id_ex_flush4, ex_mem_flush4, dmem_mask4, halt4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    localparam logic [8:0] ALL1   = 9'b1_1111_000_0;
    localparam logic [8:0] STALL  = 9'b0_0000_000_0;
    localparam logic [8:0] LU     = 9'b0_0111_010_0;
    localparam logic [8:0] BR     = 9'b1_1111_111_0;
    localparam logic [8:0] HALTIN = 9'b0_1111_111_0;
    localparam logic [8:0] DD     = 9'b0_0000_000_1;

    always #5 CLK = ~CLK;

    hazard_unit #(.CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
        .ex_dREN(ex_dREN), .ex_rfWEN(ex_rfWEN), .ex_dest(ex_dest),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .mem_brTaken(mem_brTaken), .mem_halt(mem_halt),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .dmem_mask(dmem_mask), .halt(halt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit4), .dhit(1'b0),
        .id_rs(5'd0), .id_rt(5'd0), .id_usesRt(1'b0),
        .ex_dREN(1'b0), .ex_rfWEN(1'b0), .ex_dest(5'd0),
        .mem_dREN(1'b0), .mem_dWEN(1'b0),
        .mem_brTaken(1'b0), .mem_halt(1'b0),
        .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4),
        .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
        .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
        .ex_mem_flush(ex_mem_flush4), .dmem_mask(dmem_mask4), .halt(halt4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, dmem_mask};

    typedef struct packed {
        logic       ihit, dhit;
        logic [4:0] rs, rt;
        logic       uses_rt, ex_dren, ex_rfwen;
        logic [4:0] dest;
        logic       mdr, mdw, br, mh;
        logic [8:0] exp_out;
        logic       ds, df;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        ihit = 1'b0; dhit = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_usesRt = 1'b0;
        ex_dREN = 1'b0; ex_rfWEN = 1'b0; ex_dest = 5'd0;
        mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_brTaken = 1'b0; mem_halt = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        ihit = v.ihit; dhit = v.dhit; id_rs = v.rs; id_rt = v.rt;
        id_usesRt = v.uses_rt; ex_dREN = v.ex_dren; ex_rfWEN = v.ex_rfwen;
        ex_dest = v.dest; mem_dREN = v.mdr; mem_dWEN = v.mdw;
        mem_brTaken = v.br; mem_halt = v.mh;
    endtask

    task automatic chk_cnts(input string nm);
        chk({nm, "_stall"}, {16'd0, stall_cnt}, exp_stall);
        chk({nm, "_flush"}, {16'd0, flush_cnt}, exp_flush);
    endtask

    initial begin
        //        ihit  dhit  rs    rt    use   exd   exw   dest  mdr   mdw   br    mh    exp     ds    df
        vecs[0]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ALL1,  1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU,    1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ALL1,  1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ALL1,  1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU,    1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ALL1,  1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ALL1,  1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, STALL, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ALL1,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, STALL, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, BR,    1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, STALL, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, STALL, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, LU,    1'b1, 1'b0};

        clear_in();
        ihit4 = 1'b1;
        nRST  = 1'b0;
        #1;
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_mask", {31'd0, dmem_mask}, 32'd0);
        chk_cnts("rst");
        repeat (2) @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_out", i), {23'd0, outs}, {23'd0, vecs[i].exp_out});
            @(posedge CLK);
            #1;
            exp_stall += int'(vecs[i].ds);
            exp_flush += int'(vecs[i].df);
            chk_cnts($sformatf("vec%0d", i));
            @(negedge CLK);
        end

        // Data access completes three cycles before the fetch
        clear_in();
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        mem_dREN = 1'b1; dhit = 1'b1; ihit = 1'b0;
        #1 chk("dd_k_out", {23'd0, outs}, {23'd0, STALL});
        @(negedge CLK);
        dhit = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1 chk($sformatf("dd_k%0d_out", c), {23'd0, outs}, {23'd0, DD});
            @(negedge CLK);
        end
        ihit = 1'b1;
        #1 chk("dd_k3_out", {23'd0, outs}, {23'd0, 9'b1_1111_000_1});
        @(negedge CLK);
        exp_stall = 3;
        chk_cnts("dd_k3");
        mem_dREN = 1'b0;
        #1 chk("dd_run_out", {23'd0, outs}, {23'd0, ALL1});
        @(negedge CLK);

        // Reset arriving while waiting in DDONE
        mem_dREN = 1'b1; dhit = 1'b1; ihit = 1'b0;
        @(negedge CLK);
        dhit = 1'b0;
        #1 chk("rdd_mask_before", {31'd0, dmem_mask}, 32'd1);
        nRST = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        chk("rdd_mask", {31'd0, dmem_mask}, 32'd0);
        chk("rdd_halt", {31'd0, halt}, 32'd0);
        chk_cnts("rdd");
        @(negedge CLK);
        clear_in();
        ihit = 1'b1;
        nRST = 1'b1;
        #1 chk("rdd_rel_out", {23'd0, outs}, {23'd0, ALL1});
        @(negedge CLK);

        // Halt drain and stickiness
        mem_halt = 1'b1;
        #1;
        chk("halt_in_out", {23'd0, outs}, {23'd0, HALTIN});
        chk("halt_in_flag", {31'd0, halt}, 32'd0);
        @(negedge CLK);
        for (int c = 0; c < 10; c++) begin
            clear_in();
            ihit = c[0];
            dhit = 1'b1;
            mem_brTaken = 1'b1;
            mem_dREN = ~c[0];
            ex_dREN = 1'b1; ex_rfWEN = 1'b1; ex_dest = 5'd7; id_rs = 5'd7;
            #1;
            chk($sformatf("halted%0d_out", c), {23'd0, outs}, {23'd0, DD});
            chk($sformatf("halted%0d_flag", c), {31'd0, halt}, 32'd1);
            chk_cnts($sformatf("halted%0d", c));
            @(negedge CLK);
        end

        // Counter saturation on the narrow instance
        ihit4 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK);
            #1 chk($sformatf("sat%0d", c), {28'd0, stall_cnt4}, (c > 15) ? 32'd15 : c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
